matrix_streamer: RTL and testbench
==================================

// Module: matrix_streamer
// PURPOSE
//  Source end of the matrix-entry stream consumed by the pivot search. Holds an
//  N_STOCKS x N_STOCKS matrix of WIDTH-bit entries, loaded through a write port; on
//  start, emits every entry in row-major order as a valid/ready stream tagged with
//  (row, col) and a last flag. Sits between the rate loader and the pivot search.
// PARAMETERS
//  WIDTH      16  bits per matrix entry
//  N_STOCKS   4   matrix dimension (>= 1)
//  SKIP_DIAG  0   1: entries with row == col are not emitted
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous reset, active-high
//  wr_en      in   1        write strobe for one matrix entry
//  wr_row     in   IDX_W    write row; IDX_W = max(1, $clog2(N_STOCKS))
//  wr_col     in   IDX_W    write column
//  wr_data    in   WIDTH    write data
//  wr_drop    out  1        1-cycle pulse: write discarded because busy
//  start      in   1        begin one pass over the matrix
//  axiiready  in   1        downstream ready
//  axiov      out  1        output beat valid
//  axiod      out  WIDTH    entry value
//  axiod_row  out  IDX_W    row of the entry
//  axiod_col  out  IDX_W    column of the entry
//  axiolast   out  1        final beat of the pass
//  busy       out  1        pass in progress
//  done       out  1        1-cycle pulse after the last beat transfers
// BEHAVIOUR
//  - Reset: all outputs 0; matrix cleared to 0; FSM -> IDLE. Reset mid-pass aborts
//    the pass immediately with no done pulse.
//  - FSM: IDLE -(start)-> STREAM -(last beat transferred)-> DONE -> IDLE.
//    DONE lasts exactly one cycle with done=1 and busy=0. busy=1 only in STREAM.
//  - Latency: start sampled high in IDLE at edge k -> axiov=1 with entry (0,0)
//    (or (0,1) if SKIP_DIAG) from edge k onward. Outputs are registered.
//  - Handshake: a beat transfers on a cycle where axiov && axiiready. While axiov=1 and
//    axiiready=0, axiod/axiod_row/axiod_col/axiolast hold stable. After a transfer the
//    next beat is valid the following cycle; back-to-back beats give 1 beat per cycle.
//  - Order: col increments, wraps at N_STOCKS-1 to 0 with row+1. With SKIP_DIAG, the
//    row==col index is skipped in the same cycle (no bubble).
//  - axiolast=1 only on (N-1,N-1), or (N-1,N-2) with SKIP_DIAG. Beats per pass:
//    N*N, or N*(N-1) with SKIP_DIAG.
//  - Degenerate: N_STOCKS=1 with SKIP_DIAG=1 -> zero beats; start goes IDLE->DONE.
//  - Writes: in IDLE/DONE, wr_en writes at that edge. In STREAM, the write is discarded
//    and wr_drop pulses the next cycle. A write and start in the same IDLE cycle: the
//    write commits first, so the pass emits the new value.
//  - start while busy or in DONE: ignored; no queueing.
//  - Values are unsigned, passed through unmodified.
// STRUCTURE
//  - Shared package vyapaar_pkg: IDX_W function, entry_t (logic [WIDTH-1:0]),
//    stream FSM state enum {S_IDLE, S_STREAM, S_DONE}.
//  - Sub-module matrix_regfile: N*N x WIDTH registers, 1 sync write port,
//    1 combinational read port addressed by (row, col); reset clears it.
//  - Top: FSM, row/col counters with diag-skip logic, output holding registers.
// TESTING
//  1. N=4, write (r,c)=16*r+c, start, axiiready=1 -> 16 beats 0,1,2,3,16..51 over 16
//     consecutive cycles, axiolast on value 51, done one cycle later.
//  2. Same load, SKIP_DIAG=1 -> 12 beats, no value 0/17/34/51, axiolast on (3,2)=50.
//  3. axiiready toggled 1,0,0,1,... -> no beat lost or duplicated; data stable during
//     stall; total transfer count 16.
//  4. wr_en to (1,1)=0xBEEF mid-pass -> wr_drop pulses; second pass shows (1,1)=17.
//  5. start with wr_en (0,0)=0x00AA same cycle -> first beat axiod=0x00AA.
//  6. rst asserted after 5 beats -> next cycle axiov=0, busy=0, no done; matrix all 0.

Source files
------------

// File: rtl/vyapaar_pkg.sv
// rtl/vyapaar_pkg.sv - shared types and helpers for the matrix streaming path
package vyapaar_pkg;

  localparam int DEF_WIDTH = 16;

  typedef logic [DEF_WIDTH-1:0] entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } stream_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_streamer_if.sv
// rtl/matrix_streamer_if.sv - tagged matrix-entry stream (valid/ready with row, col, last)
interface matrix_streamer_if
  import vyapaar_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 4
) ();

  localparam int IDX_W = idx_w(N_STOCKS);

  logic             axiov;
  logic             axiiready;
  logic [WIDTH-1:0] axiod;
  logic [IDX_W-1:0] axiod_row;
  logic [IDX_W-1:0] axiod_col;
  logic             axiolast;

  modport master (
    output axiov, axiod, axiod_row, axiod_col, axiolast,
    input  axiiready
  );

  modport slave (
    input  axiov, axiod, axiod_row, axiod_col, axiolast,
    output axiiready
  );

endinterface

// File: rtl/matrix_regfile.sv
// rtl/matrix_regfile.sv - N x N entry storage, one sync write port, one comb read port
module matrix_regfile #(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 4,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [IDX_W-1:0] wr_col,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_row,
  input  logic [IDX_W-1:0] rd_col,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [N_STOCKS][N_STOCKS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_STOCKS; r++) begin
        for (int c = 0; c < N_STOCKS; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/matrix_streamer.sv
// rtl/matrix_streamer.sv - holds the matrix and streams it row-major with (row, col) tags
module matrix_streamer
  import vyapaar_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int N_STOCKS  = 4,
  parameter int SKIP_DIAG = 0,
  localparam int IDX_W    = idx_w(N_STOCKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_row,
  input  logic [IDX_W-1:0]   wr_col,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               wr_drop,
  input  logic               start,
  output logic               busy,
  output logic               done,
  matrix_streamer_if.master  axo
);

  localparam bit               SKIP      = (SKIP_DIAG != 0) && (N_STOCKS > 1);
  localparam bit               EMPTY     = (SKIP_DIAG != 0) && (N_STOCKS == 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STOCKS - 1);
  localparam logic [IDX_W-1:0] FIRST_COL = SKIP ? IDX_W'(1) : '0;
  localparam logic [IDX_W-1:0] LAST_COL  = SKIP ? IDX_W'(N_STOCKS - 2) : LAST_IDX;

  stream_state_t    state_q, state_d;
  logic             v_q, last_q;
  logic [WIDTH-1:0] d_q;
  logic [IDX_W-1:0] row_q, col_q;
  logic [IDX_W-1:0] nxt_row, nxt_col, ld_row, ld_col;
  logic [WIDTH-1:0] rf_rd, ld_data;
  logic             ld_last, rf_we, xfer;

  assign xfer  = v_q && axo.axiiready;
  assign rf_we = wr_en && (state_q != S_STREAM);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = EMPTY ? S_DONE : S_STREAM;
      S_STREAM: if (xfer && last_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_STREAM);
    done = (state_q == S_DONE);
  end

  // Successor of the beat on the output; a diagonal hit is skipped in the same step.
  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q + 1'b1;
    if (col_q == LAST_IDX) begin
      nxt_col = '0;
      nxt_row = row_q + 1'b1;
    end
    if (SKIP && (nxt_row == nxt_col)) begin
      if (nxt_col == LAST_IDX) begin
        nxt_col = '0;
        nxt_row = nxt_row + 1'b1;
      end else begin
        nxt_col = nxt_col + 1'b1;
      end
    end
  end

  assign ld_row  = (state_q == S_IDLE) ? '0 : nxt_row;
  assign ld_col  = (state_q == S_IDLE) ? FIRST_COL : nxt_col;
  assign ld_last = (ld_row == LAST_IDX) && (ld_col == LAST_COL);

  // Bypass lets a write landing on the same edge as start reach the first beat.
  assign ld_data = (rf_we && (wr_row == ld_row) && (wr_col == ld_col)) ? wr_data : rf_rd;

  matrix_regfile #(
    .WIDTH    (WIDTH),
    .N_STOCKS (N_STOCKS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rf_we),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (ld_row),
    .rd_col  (ld_col),
    .rd_data (rf_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= 1'b0;
      d_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && (state_q == S_STREAM);
      if ((state_q == S_IDLE && start && !EMPTY) ||
          (state_q == S_STREAM && xfer && !last_q)) begin
        v_q    <= 1'b1;
        d_q    <= ld_data;
        row_q  <= ld_row;
        col_q  <= ld_col;
        last_q <= ld_last;
      end else if (state_q == S_STREAM && xfer) begin
        v_q    <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

  assign axo.axiov     = v_q;
  assign axo.axiod     = d_q;
  assign axo.axiod_row = row_q;
  assign axo.axiod_col = col_q;
  assign axo.axiolast  = last_q;

endmodule

// File: tb/tb_matrix_streamer.sv
// tb/tb_matrix_streamer.sv - directed checks of matrix_streamer, full and diagonal-skip variants
module tb_matrix_streamer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_row, wr_col;
  logic [15:0] wr_data;
  logic        start;
  logic        drop0, drop1, busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;

  matrix_streamer_if #(.WIDTH(16), .N_STOCKS(4)) if0 ();
  matrix_streamer_if #(.WIDTH(16), .N_STOCKS(4)) if1 ();

  matrix_streamer #(.WIDTH(16), .N_STOCKS(4), .SKIP_DIAG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .wr_drop(drop0), .start(start), .busy(busy0), .done(done0),
    .axo(if0)
  );

  matrix_streamer #(.WIDTH(16), .N_STOCKS(4), .SKIP_DIAG(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .wr_drop(drop1), .start(start), .busy(busy1), .done(done1),
    .axo(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] d0 [64];
  logic [15:0] d1 [64];
  int r0 [64], c0 [64], l0 [64], cy0 [64];
  int r1 [64], c1 [64], l1 [64], cy1 [64];
  int n0, n1, done0_cyc, done1_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input int r, input int c, input logic [15:0] d);
    wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // mode 0: always ready; mode 1: dut0 ready pattern 1,0,0 repeating.
  task automatic run_pass(input int mode, input bit pre_aa, input bit mid_wr);
    logic [31:0] held0;
    bit hp0;
    hp0 = 0; held0 = '0;
    n0 = 0; n1 = 0; done0_cyc = -1; done1_cyc = -1;
    if (pre_aa) begin
      wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 16'h00AA;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    chk("first_valid0", {31'd0, if0.axiov}, 32'd1);
    chk("first_busy0", {31'd0, busy0}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      if0.axiiready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      if1.axiiready = 1'b1;
      if (hp0)
        chk("stall_hold", {10'd0, if0.axiov, if0.axiolast, if0.axiod_row, if0.axiod_col, if0.axiod}, held0);
      if (mid_wr && i == 3) begin
        wr_en = 1'b1; wr_row = 2'd1; wr_col = 2'd1; wr_data = 16'hBEEF;
      end
      if (mid_wr && i == 4) begin
        wr_en = 1'b0;
        chk("wr_drop0", {31'd0, drop0}, 32'd1);
        chk("wr_drop1", {31'd0, drop1}, 32'd1);
      end
      if (if0.axiov && if0.axiiready && n0 < 64) begin
        d0[n0] = if0.axiod; r0[n0] = int'(if0.axiod_row); c0[n0] = int'(if0.axiod_col);
        l0[n0] = int'(if0.axiolast); cy0[n0] = i; n0++;
      end
      hp0 = if0.axiov && !if0.axiiready;
      held0 = {10'd0, if0.axiov, if0.axiolast, if0.axiod_row, if0.axiod_col, if0.axiod};
      if (if1.axiov && if1.axiiready && n1 < 64) begin
        d1[n1] = if1.axiod; r1[n1] = int'(if1.axiod_row); c1[n1] = int'(if1.axiod_col);
        l1[n1] = int'(if1.axiolast); cy1[n1] = i; n1++;
      end
      if (done0 && done0_cyc < 0) begin
        done0_cyc = i;
        chk("done_busy0", {31'd0, busy0}, 32'd0);
      end
      if (done1 && done1_cyc < 0) begin
        done1_cyc = i;
        chk("done_busy1", {31'd0, busy1}, 32'd0);
      end
      @(negedge clk);
      if (done0_cyc >= 0 && done1_cyc >= 0) break;
    end
    chk("pass_done0", {31'd0, done0_cyc >= 0}, 32'd1);
    chk("pass_done1", {31'd0, done1_cyc >= 0}, 32'd1);
    if0.axiiready = 1'b1;
  endtask

  task automatic verify(input bit expect_aa, input bit zeros, input bit cyc0_chk);
    int k;
    logic [15:0] exp;
    chk("beats0", n0, 32'd16);
    for (int j = 0; j < n0 && j < 16; j++) begin
      exp = zeros ? 16'd0 : 16'(16 * (j / 4) + (j % 4));
      if (j == 0 && expect_aa) exp = 16'h00AA;
      chk("data0", {16'd0, d0[j]}, {16'd0, exp});
      chk("row0", r0[j], j / 4);
      chk("col0", c0[j], j % 4);
      chk("last0", l0[j], (j == 15) ? 1 : 0);
      if (cyc0_chk) chk("cycle0", cy0[j], j);
    end
    if (n0 > 0) chk("done_lat0", done0_cyc, cy0[n0-1] + 1);
    chk("beats1", n1, 32'd12);
    k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r != c && k < n1) begin
          exp = zeros ? 16'd0 : 16'(16 * r + c);
          chk("data1", {16'd0, d1[k]}, {16'd0, exp});
          chk("row1", r1[k], r);
          chk("col1", c1[k], c);
          chk("last1", l1[k], (k == 11) ? 1 : 0);
          chk("cycle1", cy1[k], k);
          k++;
        end
      end
    end
    if (n1 > 0) chk("done_lat1", done1_cyc, cy1[n1-1] + 1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;
    if0.axiiready = 1'b0; if1.axiiready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, if0.axiov}, 32'd0);
    chk("rst_data", {16'd0, if0.axiod}, 32'd0);
    chk("rst_last", {31'd0, if0.axiolast}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_drop", {31'd0, drop0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_entry(r, c, 16'(16 * r + c));

    run_pass(0, 1'b0, 1'b0);
    verify(1'b0, 1'b0, 1'b1);

    run_pass(1, 1'b0, 1'b1);
    verify(1'b0, 1'b0, 1'b0);

    run_pass(0, 1'b1, 1'b0);
    verify(1'b1, 1'b0, 1'b1);
    chk("entry_1_1", {16'd0, d0[5]}, 32'd17);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if0.axiiready = 1'b1; if1.axiiready = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", {31'd0, if0.axiov}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_nodone", {31'd0, done0}, 32'd0);

    run_pass(0, 1'b0, 1'b0);
    verify(1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
